// File: rtl/leg_mem_pkg.sv
// Shared types and constants for the data-memory bus master.
package leg_mem_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    REQ_RD     = 2'b00,
    REQ_WR     = 2'b01,
    REQ_FILL   = 2'b10,
    REQ_EVFILL = 2'b11
  } mem_req_t;

  typedef enum logic [2:0] {
    StIdle,
    StSingle,
    StWriteback,
    StFill,
    StDone
  } mbm_state_t;

endpackage

// File: rtl/mem_beat_timer.sv
// Beat index within a line plus per-beat wait counter; both restart on clr.
module mem_beat_timer #(
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  localparam int unsigned IdxW = $clog2(WORDS_PER_LINE),
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            beat_ok,
  input  logic            waiting,
  output logic [IdxW-1:0] beat,
  output logic            last_beat,
  output logic            timed_out
);

  logic [IdxW-1:0] beat_q;
  logic [CntW-1:0] wait_q;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      beat_q <= '0;
      wait_q <= '0;
    end else if (beat_ok) begin
      wait_q <= '0;
      // Saturate on the last beat; the owner leaves the state on that completion.
      if (!last_beat) beat_q <= beat_q + 1'b1;
    end else if (waiting) begin
      wait_q <= wait_q + 1'b1;
    end
  end

  assign beat      = beat_q;
  assign last_beat = (beat_q == IdxW'(WORDS_PER_LINE - 1));
  assign timed_out = waiting && (wait_q == CntW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_bus_master.sv
// Data-cache to dmem bus initiator: single read/write, line fill, evict+fill with beat timeout.
module mem_bus_master
  import leg_mem_pkg::*;
#(
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  localparam int unsigned IdxW = $clog2(WORDS_PER_LINE)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ReqValid,
  output logic            ReqReady,
  input  logic [1:0]      ReqType,
  input  logic [31:0]     ReqAddr,
  input  logic [31:0]     EvictAddr,
  input  logic [31:0]     ReqWData,
  output logic [IdxW-1:0] WBWordIdx,
  input  logic [31:0]     WBData,
  output logic            FillWe,
  output logic [IdxW-1:0] FillWordIdx,
  output logic [31:0]     FillData,
  output logic            ReqDone,
  output logic            ReqErr,
  output logic [31:0]     ReqRData,
  output logic            HSEL,
  output logic            re,
  output logic            we,
  output logic [31:0]     a,
  output logic [31:0]     wd,
  input  logic [31:0]     rd,
  input  logic            Valid
);

  localparam int unsigned ByteW = $clog2(WORD_BYTES);
  localparam int unsigned LineW = IdxW + ByteW;

  mbm_state_t          state_q, state_d;
  mem_req_t            req_type_q;
  logic [31:ByteW]     req_addr_q;
  logic [31:LineW]     evict_line_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q;
  logic                err_q;

  logic                accept;
  logic                strobe;
  logic                beat_ok;
  logic                waiting;
  logic                clr;
  logic [IdxW-1:0]     beat;
  logic                last_beat;
  logic                timed_out;

  assign accept  = (state_q == StIdle) && ReqValid;
  assign strobe  = HSEL && (re || we);
  assign beat_ok = strobe && Valid;
  assign waiting = strobe && !Valid;
  assign clr     = (state_d != state_q);

  mem_beat_timer #(
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .beat_ok   (beat_ok),
    .waiting   (waiting),
    .beat      (beat),
    .last_beat (last_beat),
    .timed_out (timed_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      req_type_q   <= REQ_RD;
      req_addr_q   <= '0;
      evict_line_q <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_type_q   <= mem_req_t'(ReqType);
        req_addr_q   <= ReqAddr[31:ByteW];
        evict_line_q <= EvictAddr[31:LineW];
        wdata_q      <= ReqWData;
        err_q        <= 1'b0;
      end else if (timed_out) begin
        err_q <= 1'b1;
      end
      if (state_q == StSingle && beat_ok && req_type_q == REQ_RD) rdata_q <= rd;
    end
  end

  always_comb begin
    state_d     = state_q;
    HSEL        = 1'b0;
    re          = 1'b0;
    we          = 1'b0;
    a           = '0;
    wd          = '0;
    WBWordIdx   = '0;
    FillWe      = 1'b0;
    FillWordIdx = '0;
    unique case (state_q)
      StIdle: begin
        if (ReqValid) begin
          unique case (mem_req_t'(ReqType))
            REQ_RD, REQ_WR: state_d = StSingle;
            REQ_FILL:       state_d = StFill;
            REQ_EVFILL:     state_d = StWriteback;
            default:        state_d = StIdle;
          endcase
        end
      end
      StSingle: begin
        HSEL = 1'b1;
        re   = (req_type_q == REQ_RD);
        we   = (req_type_q == REQ_WR);
        a    = {req_addr_q, {ByteW{1'b0}}};
        wd   = wdata_q;
        if (Valid || timed_out) state_d = StDone;
      end
      StWriteback: begin
        HSEL      = 1'b1;
        we        = 1'b1;
        a         = {evict_line_q, beat, {ByteW{1'b0}}};
        wd        = WBData;
        WBWordIdx = beat;
        if (Valid && last_beat) state_d = StFill;
        else if (timed_out)     state_d = StDone;
      end
      StFill: begin
        HSEL        = 1'b1;
        re          = 1'b1;
        a           = {req_addr_q[31:LineW], beat, {ByteW{1'b0}}};
        FillWe      = Valid;
        FillWordIdx = beat;
        if ((Valid && last_beat) || timed_out) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign ReqReady = (state_q == StIdle);
  assign ReqDone  = (state_q == StDone);
  assign ReqErr   = (state_q == StDone) && err_q;
  assign ReqRData = rdata_q;
  assign FillData = rd;

endmodule

// File: tb/tb_mem_bus_master.sv
// Scoreboard bench for mem_bus_master against a small dmem responder model.
module tb_mem_bus_master;

  localparam int unsigned N = 4;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } bus_t;

  typedef struct {
    logic [1:0]  idx;
    logic [31:0] data;
  } fill_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic        chk_rdata;
    int          cyc;
  } done_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ReqValid = 1'b0;
  logic        ReqReady;
  logic [1:0]  ReqType = 2'b00;
  logic [31:0] ReqAddr = '0;
  logic [31:0] EvictAddr = '0;
  logic [31:0] ReqWData = '0;
  logic [1:0]  WBWordIdx;
  logic [31:0] WBData;
  logic        FillWe;
  logic [1:0]  FillWordIdx;
  logic [31:0] FillData;
  logic        ReqDone;
  logic        ReqErr;
  logic [31:0] ReqRData;
  logic        HSEL, re, we;
  logic [31:0] a, wd, rd;
  logic        Valid;

  logic [31:0] ram [256];
  logic [31:0] cache_line [N];
  bus_t        bus_q [$];
  fill_t       fill_q [$];
  done_t       done_q [$];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int beats_done = 0;
  int stall_cnt = 0;
  int stall_at = -1;
  int stall_len = 0;

  mem_bus_master #(
    .WORDS_PER_LINE (N),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ReqValid    (ReqValid),
    .ReqReady    (ReqReady),
    .ReqType     (ReqType),
    .ReqAddr     (ReqAddr),
    .EvictAddr   (EvictAddr),
    .ReqWData    (ReqWData),
    .WBWordIdx   (WBWordIdx),
    .WBData      (WBData),
    .FillWe      (FillWe),
    .FillWordIdx (FillWordIdx),
    .FillData    (FillData),
    .ReqDone     (ReqDone),
    .ReqErr      (ReqErr),
    .ReqRData    (ReqRData),
    .HSEL        (HSEL),
    .re          (re),
    .we          (we),
    .a           (a),
    .wd          (wd),
    .rd          (rd),
    .Valid       (Valid)
  );

  always #5 clk = ~clk;

  assign WBData = cache_line[WBWordIdx];
  assign rd     = ram[a[9:2]];
  assign Valid  = HSEL && (re || we) && !(beats_done == stall_at && stall_cnt < stall_len);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (HSEL && we && Valid) ram[a[9:2]] <= wd;
    if (reset || (ReqValid && ReqReady)) begin
      beats_done <= 0;
      stall_cnt  <= 0;
    end else if (HSEL && (re || we)) begin
      if (Valid) begin
        beats_done <= beats_done + 1;
        stall_cnt  <= 0;
      end else begin
        stall_cnt <= stall_cnt + 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: every completed beat, fill word and done pulse pops an expectation.
  always @(negedge clk) begin
    if (HSEL && (re || we) && Valid) begin
      check_eq("bus_expected", 32'(bus_q.size() > 0), 32'd1);
      if (bus_q.size() > 0) begin
        bus_t b;
        b = bus_q.pop_front();
        check_eq("bus_we", {31'd0, we}, {31'd0, b.we});
        check_eq("bus_a", a, b.addr);
        if (b.we) check_eq("bus_wd", wd, b.data);
      end
    end
    if (FillWe) begin
      check_eq("fill_expected", 32'(fill_q.size() > 0), 32'd1);
      if (fill_q.size() > 0) begin
        fill_t f;
        f = fill_q.pop_front();
        check_eq("fill_idx", {30'd0, FillWordIdx}, {30'd0, f.idx});
        check_eq("fill_data", FillData, f.data);
      end
    end
    if (ReqDone) begin
      check_eq("done_expected", 32'(done_q.size() > 0), 32'd1);
      if (done_q.size() > 0) begin
        done_t d;
        d = done_q.pop_front();
        check_eq("done_err", {31'd0, ReqErr}, {31'd0, d.err});
        check_eq("done_cycle", cyc, d.cyc);
        if (d.chk_rdata) check_eq("rdata", ReqRData, d.rdata);
      end
    end
  end

  task automatic run_req(input logic [1:0] t, input logic [31:0] ad, input logic [31:0] ev,
                         input logic [31:0] wdat, input int n_wb, input int n_fill,
                         input logic exp_err, input int lat, input logic do_done);
    bus_t  b;
    fill_t f;
    done_t d;
    logic [31:0] eb;
    logic [31:0] fb;
    eb = {ev[31:4], 4'h0};
    fb = {ad[31:4], 4'h0};
    @(negedge clk);
    for (int k = 0; k < 50 && !ReqReady; k++) @(negedge clk);
    check_eq("ready", {31'd0, ReqReady}, 32'd1);
    ReqType = t; ReqAddr = ad; EvictAddr = ev; ReqWData = wdat; ReqValid = 1'b1;
    if (!t[1]) begin
      b.we = t[0]; b.addr = {ad[31:2], 2'b00}; b.data = wdat;
      bus_q.push_back(b);
    end else begin
      for (int i = 0; i < n_wb; i++) begin
        b.we = 1'b1; b.addr = eb + 32'(4 * i); b.data = cache_line[i];
        bus_q.push_back(b);
      end
      for (int i = 0; i < n_fill; i++) begin
        b.we = 1'b0; b.addr = fb + 32'(4 * i); b.data = '0;
        bus_q.push_back(b);
        f.idx = 2'(i); f.data = ram[b.addr[9:2]];
        fill_q.push_back(f);
      end
    end
    if (do_done) begin
      d.err = exp_err; d.rdata = ram[ad[9:2]]; d.chk_rdata = (t == 2'b00) && !exp_err;
      d.cyc = cyc + lat;
      done_q.push_back(d);
    end
    @(negedge clk);
    ReqValid = 1'b0;
    if (do_done) begin
      for (int k = 0; k < 100 && done_q.size() != 0; k++) @(posedge clk);
      check_eq("done_drained", 32'(done_q.size()), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = {16'hC0DE, 16'(i)};
    ram[32'h10 >> 2] = 32'hDEADBEEF;
    for (int i = 0; i < N; i++) cache_line[i] = 32'hCAFE0000 + 32'(i);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", {31'd0, ReqReady}, 32'd1);
    check_eq("rst_strobes", {29'd0, HSEL, re, we}, 32'd0);
    check_eq("rst_flags", {29'd0, FillWe, ReqDone, ReqErr}, 32'd0);
    check_eq("rst_a", a, 32'd0);
    check_eq("rst_wd", wd, 32'd0);
    check_eq("rst_rdata", ReqRData, 32'd0);
    reset = 1'b0;

    // Single read, single write with readback
    run_req(2'b00, 32'h12, 32'h0, 32'h0, 0, 0, 1'b0, 2, 1'b1);
    check_eq("rd_hold", ReqRData, 32'hDEADBEEF);
    run_req(2'b01, 32'h20, 32'h0, 32'h12345678, 0, 0, 1'b0, 2, 1'b1);
    check_eq("wr_mem", ram[32'h20 >> 2], 32'h12345678);
    run_req(2'b00, 32'h20, 32'h0, 32'h0, 0, 0, 1'b0, 2, 1'b1);
    check_eq("wr_readback", ReqRData, 32'h12345678);

    // Line fill, then evict+fill
    run_req(2'b10, 32'h104, 32'h0, 32'h0, 0, N, 1'b0, N + 1, 1'b1);
    run_req(2'b11, 32'h300, 32'h208, 32'h0, N, N, 1'b0, 2 * N + 1, 1'b1);
    for (int i = 0; i < N; i++) check_eq("wb_mem", ram[(32'h200 >> 2) + i], cache_line[i]);

    // Beat 1 never answered: timeout after 16 wait cycles, only word 0 delivered
    stall_at = 1; stall_len = 1000;
    run_req(2'b10, 32'h140, 32'h0, 32'h0, 0, 1, 1'b1, 18, 1'b1);
    @(negedge clk);
    check_eq("post_timeout_strobes", {29'd0, HSEL, re, we}, 32'd0);
    // Failed writeback skips the fill entirely
    run_req(2'b11, 32'h180, 32'h240, 32'h0, 1, 0, 1'b1, 18, 1'b1);
    // A 3-cycle stall recovers without error
    stall_len = 3;
    run_req(2'b10, 32'h140, 32'h0, 32'h0, 0, N, 1'b0, N + 1 + 3, 1'b1);
    stall_at = -1; stall_len = 0;

    // Reset during fill beat 2
    run_req(2'b10, 32'h1C0, 32'h0, 32'h0, 0, 3, 1'b0, 0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("abort_strobes", {29'd0, HSEL, re, we}, 32'd0);
    check_eq("abort_fillwe", {31'd0, FillWe}, 32'd0);
    check_eq("abort_ready", {31'd0, ReqReady}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("abort_no_done", {31'd0, ReqDone}, 32'd0);
    run_req(2'b00, 32'h12, 32'h0, 32'h0, 0, 0, 1'b0, 2, 1'b1);

    repeat (2) @(negedge clk);
    check_eq("bus_q_empty", 32'(bus_q.size()), 32'd0);
    check_eq("fill_q_empty", 32'(fill_q.size()), 32'd0);
    check_eq("done_q_empty", 32'(done_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
